// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP accumulator CPU.
//   - opcode encodings (4-bit opcode field at the top of each instruction word)
//   - run/halt FSM state encoding
//   - helpers locating the opcode field for a given data width
package sap_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_JC  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hA;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_EXEC     = 3'd2,
      ST_ALU      = 3'd3,
      ST_OUT_WAIT = 3'd4,
      ST_HALT     = 3'd5
   } state_e;

   // Opcode occupies the four most significant bits of the instruction word.
   function automatic int opc_msb(input int data_w);
      return data_w - 1;
   endfunction

   function automatic int opc_lsb(input int data_w);
      return data_w - 4;
   endfunction

endpackage

// File: rtl/sap_alu.sv
// sap_alu: combinational DATA_W-bit adder/subtractor.
//   a_i, b_i  : operands
//   sub_i     : 1 = a_i - b_i (as a + ~b + 1), 0 = a_i + b_i
//   result_o  : modular result
//   carry_o   : carry out of the MSB (for SUB, 1 means no borrow)
//   zero_o    : result == 0
module sap_alu #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sub_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;

   always_comb begin
      b_eff    = sub_i ? ~b_i : b_i;
      sum      = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
      result_o = sum[DATA_W-1:0];
      carry_o  = sum[DATA_W];
      zero_o   = (sum[DATA_W-1:0] == '0);
   end

endmodule

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: parametrised accumulator CPU with run/halt FSM.
//   wb_clk_i, wb_rst_n      : clock, synchronous active-low reset
//   run                     : level, starts execution from IDLE
//   load_en/addr/data       : RAM write port, honoured only in IDLE or HALT
//   out_data/valid/ready    : OUT instruction result, valid/ready handshake
//   halted                  : high once HLT has executed
//   acc_o, pc_o, flags_o    : accumulator, program counter, {carry, zero}
// DATA_W must be at least ADDR_W+4 so opcode and operand fields do not overlap.
module sap_cpu_core
   import sap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              run,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              halted,
   output logic [DATA_W-1:0] acc_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [1:0]        flags_o
);

   localparam int OPC_LSB = opc_lsb(DATA_W);

   // RAM is deliberately left out of reset so a loaded program survives it.
   logic [DATA_W-1:0] ram_q [2**ADDR_W];

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              halted_q, halted_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry, alu_zero;
   logic              ir_unused;

   assign opcode    = ir_q[OPC_LSB +: 4];
   assign operand   = ir_q[ADDR_W-1:0];
   // Bits between the opcode and operand fields carry no meaning.
   assign ir_unused = ^ir_q;

   // IR still holds the ADD/SUB instruction while in ALU, so it selects the op.
   sap_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .sub_i    (opcode == OP_SUB),
      .result_o (alu_result),
      .carry_o  (alu_carry),
      .zero_o   (alu_zero)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      ir_d        = ir_q;
      pc_d        = pc_q;
      c_d         = c_q;
      z_d         = z_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      halted_d    = halted_q;

      unique case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_d    = ram_q[pc_q];
            pc_d    = pc_q + 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            unique case (opcode)
               OP_LDA: a_d = ram_q[operand];
               OP_ADD, OP_SUB: begin
                  b_d     = ram_q[operand];
                  state_d = ST_ALU;
               end
               OP_LDI: a_d = DATA_W'(operand);
               OP_JMP: pc_d = operand;
               OP_JZ:  if (z_q) pc_d = operand;
               OP_JC:  if (c_q) pc_d = operand;
               OP_OUT: begin
                  out_data_d  = a_q;
                  out_valid_d = 1'b1;
                  state_d     = ST_OUT_WAIT;
               end
               OP_HLT: begin
                  halted_d = 1'b1;
                  state_d  = ST_HALT;
               end
               default: ;  // NOP, STA (handled on the RAM port), B..F
            endcase
         end
         ST_ALU: begin
            a_d     = alu_result;
            c_d     = alu_carry;
            z_d     = alu_zero;
            state_d = ST_FETCH;
         end
         ST_OUT_WAIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_FETCH;
            end
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM write port: STA only occurs in EXEC, external loads only in IDLE/HALT,
   // so the two sources never compete.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = load_addr;
      ram_wdata = load_data;
      if (wb_rst_n && state_q == ST_EXEC && opcode == OP_STA) begin
         ram_we    = 1'b1;
         ram_waddr = operand;
         ram_wdata = a_q;
      end else if (load_en && (state_q == ST_IDLE || state_q == ST_HALT)) begin
         ram_we = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (ram_we) ram_q[ram_waddr] <= ram_wdata;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         ir_q        <= '0;
         pc_q        <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ir_q        <= ir_d;
         pc_q        <= pc_d;
         c_q         <= c_d;
         z_q         <= z_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign acc_o     = a_q;
   assign pc_o      = pc_q;
   assign flags_o   = {c_q, z_q};

endmodule

// File: doc/sap_cpu_core.md
# sap_cpu_core

Parametrised accumulator CPU core for the user project area. It generalises the existing 8-bit, 16-word design to configurable data width and RAM depth. It adds a carry-conditional jump, a valid/ready output port and an explicit run/halt FSM with a guarded RAM load port. The core is instantiated by the user-project wrapper, which maps the load/run controls and status onto logic-analyzer bits.

## Interface
Parameters:
- DATA_W, 8, data/instruction word width; must be ≥ ADDR_W+4.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W words.

Ports:
- wb_clk_i  in  1  sole clock; all state updates on its rising edge.
- wb_rst_n  in  1  reset, synchronous, active-low.
- run  in  1  level; starts execution from IDLE.
- load_en  in  1  RAM write strobe; honoured only in IDLE or HALT.
- load_addr  in  ADDR_W  RAM write address.
- load_data  in  DATA_W  RAM write data.
- out_data  out  DATA_W  value captured by OUT; reset 0.
- out_valid  out  1  out_data pending; reset 0.
- out_ready  in  1  consumer accepts out_data.
- halted  out  1  high in HALT; reset 0.
- acc_o  out  DATA_W  accumulator A; reset 0.
- pc_o  out  ADDR_W  program counter; reset 0.
- flags_o  out  2  {carry, zero}; reset 0.

## Operation
- Instruction word: opcode = bits [DATA_W-1:DATA_W-4], operand = bits [ADDR_W-1:0]. The bits between these two fields are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDA: A ← ram[op].
  - 2 ADD: B ← ram[op], then A ← A+B.
  - 3 SUB: B ← ram[op], then A ← A−B.
  - 4 STA: ram[op] ← A.
  - 5 LDI: A ← zero-extended op.
  - 6 JMP: pc ← op.
  - 7 JZ: pc ← op if Z.
  - 8 JC: pc ← op if C.
  - 9 OUT.
  - A HLT.
  - B–F execute as NOP.
- FSM states IDLE, FETCH, EXEC, ALU, OUT_WAIT, HALT:
  - IDLE: run=1 → FETCH.
  - FETCH: IR ← ram[pc]; pc ← pc+1 mod 2**ADDR_W → EXEC.
  - EXEC: perform the opcode.
    - ADD/SUB → ALU.
    - OUT: out_data ← A, out_valid ← 1 → OUT_WAIT.
    - HLT → HALT.
    - All others → FETCH.
  - ALU: A ← result; Z and C updated → FETCH.
  - OUT_WAIT: stay while out_ready=0. When out_ready=1, clear out_valid → FETCH.
  - HALT: terminal. Only reset leaves it.
- Arithmetic: DATA_W-bit modular.
  - ADD: C = carry out.
  - SUB: computed as A + ~B + 1; C = carry out, i.e. 1 means no borrow (A ≥ B).
  - Z = (result == 0).
  - Only ADD/SUB modify flags.
- run=0 after leaving IDLE has no effect. Execution continues to HLT.
- RAM: asynchronous read, synchronous write. Not cleared by reset.
- If STA (EXEC) and a load_en would hit the same address in one cycle, STA wins, because load_en is ignored outside IDLE/HALT.
- load_en and run together in IDLE: the write is committed and the FSM enters FETCH. FETCH sees the written word.

## Timing
- Cycles per instruction:
  - 2 for most opcodes (FETCH+EXEC).
  - 3 for ADD/SUB.
  - OUT: 2 + number of OUT_WAIT cycles, minimum 1.
- run sampled high in IDLE → first FETCH on the next cycle.
- out_valid rises on the edge that ends EXEC. out_data is stable while out_valid=1. The transfer occurs on the edge where out_valid & out_ready.
- JZ/JC use the flags as registered before EXEC.
- A taken jump overrides the FETCH increment. The next FETCH reads ram[op].
- wb_rst_n=0 sampled at any edge, including mid-ALU or in OUT_WAIT:
  - state → IDLE.
  - A, B, IR, pc, flags, out_data, out_valid, halted → 0.
  - A pending OUT is dropped.

## Structure
- Shared package sap_pkg holds:
  - Opcode localparams (OP_NOP … OP_HLT).
  - FSM state encoding.
  - Field-position helpers derived from DATA_W/ADDR_W.
- One sub-module, sap_alu: combinational add/sub with sub select, producing result, carry and zero. Same width as DATA_W.
- The RAM array, FSM and register file stay in sap_cpu_core.

## Test plan
- Reset/idle: hold wb_rst_n=0 for 2 cycles, then release with run=0 → all outputs 0, FSM stays IDLE, halted=0.
- Load and add (DATA_W=8, ADDR_W=4):
  - Load ram[0..3] = 0x1E, 0x2F, 0x90, 0xA0; ram[14]=0x05; ram[15]=0xFE.
  - Pulse run with out_ready=1.
  - Expect out_data=0x03, C=1, Z=0, then halted=1.
- SUB borrow/zero, JZ: LDI 3; SUB ram[x]=3; JZ to an OUT → A=0, Z=1, C=1, jump taken, out_data=0x00.
- JC not taken after ADD 1+1: the sequential path executes; the pc_o trace matches.
- Backpressure: OUT with out_ready=0 for 5 cycles → out_valid held and pc_o frozen. out_ready=1 → one transfer and execution resumes. Reset asserted during OUT_WAIT → out_valid=0 the next cycle.
- Parameter sweep DATA_W=12, ADDR_W=6:
  - Wrap: pc=63 with NOP at 63 → pc_o=0.
  - Load attempts while running are ignored: RAM readback via LDA/OUT is unchanged.
